// File: rtl/ibus_mem_slave_if.sv
// ibus -- request/response bus between an instruction fetcher and a memory slave.
//   req.adr     : request byte address (ALEN bits)
//   req_valid   : master -> slave, request present
//   req_ready   : slave -> master, request may be accepted this cycle
//   resp.data   : response data (XLEN bits)
//   resp.status : 1'b0 = OK, 1'b1 = ERROR
//   resp_valid  : slave -> master, response present
//   resp_ready  : master -> slave, response may be consumed this cycle
interface ibus #(
  parameter int ALEN = 32,
  parameter int XLEN = 32
) ();

  typedef struct packed {
    logic [ALEN-1:0] adr;
  } req_t;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            status;
  } resp_t;

  req_t  req;
  logic  req_valid;
  logic  req_ready;
  resp_t resp;
  logic  resp_valid;
  logic  resp_ready;

  modport slave (
    input  req, req_valid, resp_ready,
    output req_ready, resp, resp_valid
  );

  modport master (
    output req, req_valid, resp_ready,
    input  req_ready, resp, resp_valid
  );

endinterface

// File: rtl/ibus_mem_slave.sv
// ibus_mem_slave -- word-addressed memory behind an ibus slave port.
//   Reads complete with one cycle of latency through a 2-entry in-order
//   response FIFO; a side load port writes memory words independently.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (memory contents are kept)
//   bus     : ibus.slave request/response port
//   ld_en   : load strobe
//   ld_idx  : word index to load
//   ld_data : load data
// Build option: define IBUS_MEM_SLAVE_ERR_CHECK_EN to return ERROR (data 0)
//   for misaligned or out-of-window addresses; otherwise low address bits are
//   ignored, the index wraps modulo DEPTH and status is always OK.
module ibus_mem_slave #(
  parameter int              ALEN  = 32,
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 1024,
  parameter logic [ALEN-1:0] BASE  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  ibus.slave                       bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [XLEN-1:0]          ld_data
);

  localparam int   IDXW  = $clog2(DEPTH);
  localparam int   WSH   = $clog2(XLEN / 8);
  localparam logic ST_OK = 1'b0;

  logic [XLEN-1:0] mem [DEPTH];

  logic [1:0]      cnt;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [XLEN-1:0] fifo_data   [2];
  logic            fifo_status [2];

  logic            push;
  logic            pop;
  logic [ALEN-1:0] offset;
  logic [IDXW-1:0] rd_idx;
  logic            rd_err;

  assign bus.req_ready  = !rst && (cnt < 2'd2);
  assign bus.resp_valid = !rst && (cnt != 2'd0);

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = bus.resp_valid && bus.resp_ready;

  assign offset = bus.req.adr - BASE;
  assign rd_idx = offset[WSH +: IDXW];

`ifdef IBUS_MEM_SLAVE_ERR_CHECK_EN
  localparam logic            ST_ERROR = 1'b1;
  localparam logic [63:0]     SPAN     = 64'(DEPTH) * 64'(XLEN / 8);
  localparam logic [ALEN-1:0] LOW_MASK = ALEN'((64'd1 << WSH) - 64'd1);

  logic misaligned;
  logic below;
  logic above;

  assign misaligned = |(bus.req.adr & LOW_MASK);
  assign below      = bus.req.adr < BASE;
  // offset is only meaningful when the address is not below BASE
  assign above      = 64'(offset) >= SPAN;
  assign rd_err     = misaligned || below || above;
`else
  logic unused_offset_bits;

  assign unused_offset_bits = ^offset;
  assign rd_err             = 1'b0;
`endif

  // Outputs are forced to idle values while reset is held, even though the
  // FIFO state only clears at the reset edge.
  assign bus.resp.data   = bus.resp_valid ? fifo_data[rd_ptr]   : '0;
  assign bus.resp.status = bus.resp_valid ? fifo_status[rd_ptr] : ST_OK;

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // cnt doubles as the FIFO occupancy: every accepted read enters the FIFO at
  // its acceptance edge, so the response is visible the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // The memory read samples the pre-load word when a load hits the same
  // index at the acceptance edge.
  always_ff @(posedge clk) begin
    if (push) begin
`ifdef IBUS_MEM_SLAVE_ERR_CHECK_EN
      fifo_data[wr_ptr]   <= rd_err ? '0 : mem[rd_idx];
      fifo_status[wr_ptr] <= rd_err ? ST_ERROR : ST_OK;
`else
      fifo_data[wr_ptr]   <= mem[rd_idx];
      fifo_status[wr_ptr] <= rd_err;
`endif
    end
  end

endmodule
